apb3_debug_slave_v2: RTL

APB3_DEBUG_SLAVE_V2 -- requirements
Module: apb3_debug_slave_v2

---
 rtl/apb3_debug_slave_v2_if.sv | 25 ++
 rtl/apb3_debug_slave_v2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb3_debug_slave_v2_if.sv
// rtl/apb3_debug_slave_v2_if.sv - APB3 request/response bundle for the debug slave
//
// Signals: paddr[11:0], psel, penable, pwrite, pwdata[31:0] (requester -> slave)
//          prdata[31:0], pready, pslverr                    (slave -> requester)
// Modports: master (bus requester), slave (debug block).
interface apb3_debug_slave_v2_if;
  logic [11:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb3_debug_slave_v2.sv
// rtl/apb3_debug_slave_v2.sv - APB3 debug slave: run control, PC/INSTR, breakpoints, GPR handshake
//
// Optional feature macro: APB_DBG_TIMEOUT_EN (GPR handshake timeout; off by default).
//
// Ports:
//   clk, rst              sole clock, synchronous active-high reset
//   apb                   APB3 slave port (apb3_debug_slave_v2_if.slave)
//   dbg_*_req             single-cycle halt/resume/step/reset command pulses
//   dbg_halted/_cause     CPU halted flag and halt cause
//   dbg_pc_*              PC write strobe/data, PC read value
//   dbg_instr             current instruction
//   dbg_reg_*             GPR request/ack handshake
//   bp_addr, bp_en        breakpoint comparator addresses (packed) and enables
package apb3_debug_slave_v2_pkg;
  localparam int XLEN           = 32;
  localparam int ILEN           = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [3:0] {
    HC_NONE    = 4'd0,
    HC_EBREAK  = 4'd1,
    HC_BREAKPT = 4'd2,
    HC_STEP    = 4'd3,
    HC_HALTREQ = 4'd4,
    HC_RESET   = 4'd5
  } halt_cause_e;
endpackage

module apb3_debug_slave_v2
  import apb3_debug_slave_v2_pkg::*;
#(
  parameter int NUM_BP         = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  apb3_debug_slave_v2_if.slave       apb,
  output logic                       dbg_halt_req,
  output logic                       dbg_resume_req,
  output logic                       dbg_step_req,
  output logic                       dbg_reset_req,
  input  logic                       dbg_halted,
  input  halt_cause_e                dbg_halt_cause,
  output logic                       dbg_pc_we,
  output logic [XLEN-1:0]            dbg_pc_wdata,
  input  logic [XLEN-1:0]            dbg_pc_rdata,
  input  logic [ILEN-1:0]            dbg_instr,
  output logic                       dbg_reg_req,
  output logic                       dbg_reg_we,
  output logic [REG_ADDR_WIDTH-1:0]  dbg_reg_addr,
  output logic [XLEN-1:0]            dbg_reg_wdata,
  input  logic                       dbg_reg_ack,
  input  logic [XLEN-1:0]            dbg_reg_rdata,
  output logic [NUM_BP*XLEN-1:0]     bp_addr,
  output logic [NUM_BP-1:0]          bp_en
);

  localparam logic [3:0] NUM_BP_L = 4'(NUM_BP);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } gpr_state_e;

  gpr_state_e state_q, state_d;

  // Register state
  logic [3:0]                   cmd_q;
  logic [NUM_BP-1:0]            bp_en_q;
  logic [NUM_BP-1:0][XLEN-1:0]  bp_addr_q;
  logic [7:0]                   halt_cnt_q;
  logic                         halted_q;

  // GPR transaction state
  logic [REG_ADDR_WIDTH-1:0]    gpr_addr_q;
  logic                         gpr_we_q;
  logic [XLEN-1:0]              gpr_wdata_q;
  logic [XLEN-1:0]              rdata_q;
  logic                         rerr_q;
  logic                         timeout;

  // Address decode
  logic [9:0]  word;
  logic        sel_ctrl, sel_status, sel_pc, sel_instr, sel_bpen, sel_bp, sel_gpr;
  logic [2:0]  bp_idx;
  logic        bp_ok, mapped, bad;
  logic        access, idle_acc, gpr_start, reg_ok, reg_err;
  logic        halt_rise;
  logic [31:0] status_word, rd_mux, rd_bp;

  always_comb begin
    word       = apb.paddr[11:2];
    sel_ctrl   = (word == 10'h000);
    sel_status = (word == 10'h001);
    sel_pc     = (word == 10'h002);
    sel_instr  = (word == 10'h003);
    sel_bpen   = (word == 10'h004);
    sel_bp     = (word[9:3] == 7'b0000010);
    bp_idx     = word[2:0];
    bp_ok      = sel_bp && ({1'b0, bp_idx} < NUM_BP_L);
    sel_gpr    = (word[9:5] == 5'b01000);
    mapped     = sel_ctrl | sel_status | sel_pc | sel_instr | sel_bpen | bp_ok | sel_gpr;
    // GPR access of either direction needs a halted CPU to service it, so a
    // running CPU turns it into an immediate error rather than a hung bus.
    bad        = !mapped
               | (apb.pwrite & (sel_status | sel_instr))
               | (((sel_pc & apb.pwrite) | sel_gpr) & !dbg_halted);
    access     = apb.psel & apb.penable & !rst;
    idle_acc   = access & (state_q == ST_IDLE);
    gpr_start  = idle_acc & sel_gpr & dbg_halted;
    reg_ok     = idle_acc & !bad & !sel_gpr;
    reg_err    = idle_acc & bad;
    halt_rise  = dbg_halted & !halted_q;
  end

  assign status_word = {16'b0, halt_cnt_q, 4'(dbg_halt_cause), 2'b0, !dbg_halted, dbg_halted};

  always_comb begin
    rd_bp = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      if (bp_idx == 3'(i)) rd_bp = bp_addr_q[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    if (sel_status)     rd_mux = status_word;
    else if (sel_pc)    rd_mux = dbg_pc_rdata;
    else if (sel_instr) rd_mux = dbg_instr;
    else if (sel_bpen)  rd_mux = 32'(bp_en_q);
    else if (bp_ok)     rd_mux = rd_bp;
  end

  // Register file, command pulses and halt-edge counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_q      <= '0;
      bp_en_q    <= '0;
      bp_addr_q  <= '0;
      halt_cnt_q <= '0;
      // Capture the current level so a CPU already halted at reset is not
      // counted as a fresh halt edge.
      halted_q   <= dbg_halted;
    end else begin
      halted_q <= dbg_halted;
      cmd_q    <= (reg_ok && apb.pwrite && sel_ctrl) ? apb.pwdata[3:0] : 4'h0;
      if (reg_ok && apb.pwrite && sel_bpen) bp_en_q <= apb.pwdata[NUM_BP-1:0];
      for (int i = 0; i < NUM_BP; i++) begin
        if (reg_ok && apb.pwrite && bp_ok && (bp_idx == 3'(i))) bp_addr_q[i] <= apb.pwdata;
      end
      // A halt edge coinciding with the clearing read is kept, not lost.
      if (reg_ok && !apb.pwrite && sel_status) halt_cnt_q <= {7'b0, halt_rise};
      else if (halt_rise && (halt_cnt_q != 8'hFF)) halt_cnt_q <= halt_cnt_q + 8'd1;
    end
  end

  assign dbg_halt_req   = cmd_q[0];
  assign dbg_resume_req = cmd_q[1];
  assign dbg_step_req   = cmd_q[2];
  assign dbg_reset_req  = cmd_q[3];
  assign bp_en          = bp_en_q;
  assign bp_addr        = bp_addr_q;
  assign dbg_pc_wdata   = apb.pwdata;

`ifdef APB_DBG_TIMEOUT_EN
  logic [9:0] to_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || (state_q != ST_REQ)) to_cnt_q <= '0;
    else                            to_cnt_q <= to_cnt_q + 10'd1;
  end

  assign timeout = (state_q == ST_REQ) && (to_cnt_q == 10'(TIMEOUT_CYCLES - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^10'(TIMEOUT_CYCLES);
  assign timeout        = 1'b0;
`endif

  logic unused_paddr;
  assign unused_paddr = ^apb.paddr[1:0];

  // GPR FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // GPR FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (gpr_start) state_d = ST_REQ;
      ST_REQ: begin
        // A dropped psel abandons the transfer; dbg_halted is deliberately
        // not consulted so an in-flight handshake always completes.
        if (!apb.psel)                 state_d = ST_IDLE;
        else if (dbg_reg_ack || timeout) state_d = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // GPR transaction capture
  always_ff @(posedge clk) begin
    if (rst) begin
      gpr_addr_q  <= '0;
      gpr_we_q    <= 1'b0;
      gpr_wdata_q <= '0;
      rdata_q     <= '0;
      rerr_q      <= 1'b0;
    end else begin
      if (gpr_start) begin
        gpr_addr_q  <= word[4:0];
        gpr_we_q    <= apb.pwrite;
        gpr_wdata_q <= apb.pwdata;
      end
      if (state_q == ST_REQ) begin
        if (dbg_reg_ack) begin
          rdata_q <= gpr_we_q ? '0 : dbg_reg_rdata;
          rerr_q  <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          rerr_q  <= 1'b1;
        end
      end
    end
  end

  assign dbg_reg_we    = gpr_we_q;
  assign dbg_reg_addr  = gpr_addr_q;
  assign dbg_reg_wdata = gpr_wdata_q;

  // GPR FSM + register response: outputs
  always_comb begin
    apb.pready  = 1'b0;
    apb.pslverr = 1'b0;
    apb.prdata  = '0;
    dbg_reg_req = 1'b0;
    dbg_pc_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (reg_ok) begin
          apb.pready = 1'b1;
          apb.prdata = apb.pwrite ? 32'h0 : rd_mux;
          dbg_pc_we  = apb.pwrite & sel_pc;
        end else if (reg_err) begin
          apb.pready  = 1'b1;
          apb.pslverr = 1'b1;
        end
      end
      ST_REQ: dbg_reg_req = 1'b1;
      ST_RESP: begin
        if (access) begin
          apb.pready  = 1'b1;
          apb.pslverr = rerr_q;
          apb.prdata  = rdata_q;
        end
      end
      default: ;
    endcase
  end

endmodule
